// File: rtl/csr_file.sv
// Machine-mode CSR file: status, trap vector/return state, scratch,
// cycle/instret counters and read-only identification registers.
module csr_file #(
  parameter int             N      = 64,
  parameter logic [N-1:0]   HARTID = '0,
  parameter logic [N-1:0]   MISA   = N'(64'h8000_0000_0000_0100)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [11:0]  addr,
  input  logic         en,
  input  logic [1:0]   op,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         illegal,
  input  logic         retire,
  input  logic         trap,
  input  logic [N-1:0] trap_pc,
  input  logic [N-1:0] trap_cause,
  input  logic         mret,
  output logic [N-1:0] mtvec_o,
  output logic [N-1:0] mepc_o,
  output logic         mie_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MVENDOR  = 12'hF11;
  localparam logic [11:0] A_MARCH    = 12'hF12;
  localparam logic [11:0] A_MIMP     = 12'hF13;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  logic         r_st_mie;
  logic         r_st_mpie;
  logic [N-1:0] r_mie;
  logic [N-1:0] r_mtvec;
  logic [N-1:0] r_mscratch;
  logic [N-1:0] r_mepc;
  logic [N-1:0] r_mcause;
  logic [N-1:0] r_mcycle;
  logic [N-1:0] r_minstret;

  logic [N-1:0] w_mstatus;
  logic [N-1:0] w_rdata;
  logic [N-1:0] w_wdata;
  logic         w_mapped;
  logic         w_ro;
  logic         w_wr_att;
  logic         w_wr;
  logic         w_sys_evt;

  always_comb begin
    w_mstatus    = '0;
    w_mstatus[3] = r_st_mie;
    w_mstatus[7] = r_st_mpie;
  end

  always_comb begin
    w_mapped = 1'b1;
    w_rdata  = '0;
    unique case (addr)
      A_MSTATUS:  w_rdata = w_mstatus;
      A_MISA:     w_rdata = MISA;
      A_MIE:      w_rdata = r_mie;
      A_MTVEC:    w_rdata = r_mtvec;
      A_MSCRATCH: w_rdata = r_mscratch;
      A_MEPC:     w_rdata = r_mepc;
      A_MCAUSE:   w_rdata = r_mcause;
      A_MCYCLE:   w_rdata = r_mcycle;
      A_MINSTRET: w_rdata = r_minstret;
      A_MVENDOR:  w_rdata = '0;
      A_MARCH:    w_rdata = '0;
      A_MIMP:     w_rdata = '0;
      A_MHARTID:  w_rdata = HARTID;
      default:    w_mapped = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read and may target RO CSRs.
  assign w_wr_att  = en && (op == 2'b01 || (op[1] && din != '0));
  assign w_ro      = (addr[11:10] == 2'b11) || (addr == A_MISA);
  assign illegal   = en && (!w_mapped || (w_wr_att && w_ro));
  assign w_wr      = w_wr_att && !illegal;
  assign w_sys_evt = trap || mret;
  assign dout      = w_rdata;

  always_comb begin
    unique case (op)
      2'b01:   w_wdata = din;
      2'b10:   w_wdata = w_rdata | din;
      2'b11:   w_wdata = w_rdata & ~din;
      default: w_wdata = w_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st_mie   <= 1'b0;
      r_st_mpie  <= 1'b0;
      r_mie      <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      // Trap and mret own mstatus/mepc/mcause; a colliding write is lost.
      if (trap) begin
        r_mepc    <= {trap_pc[N-1:1], 1'b0};
        r_mcause  <= trap_cause;
        r_st_mpie <= r_st_mie;
        r_st_mie  <= 1'b0;
      end else if (mret) begin
        r_st_mie  <= r_st_mpie;
        r_st_mpie <= 1'b1;
      end else if (w_wr) begin
        if (addr == A_MSTATUS) begin
          r_st_mie  <= w_wdata[3];
          r_st_mpie <= w_wdata[7];
        end
        if (addr == A_MEPC)
          r_mepc <= {w_wdata[N-1:1], 1'b0};
        if (addr == A_MCAUSE)
          r_mcause <= w_wdata;
      end
      if (w_wr && addr == A_MIE)
        r_mie <= w_wdata;
      if (w_wr && addr == A_MTVEC)
        r_mtvec <= {w_wdata[N-1:2], 2'b00};
      if (w_wr && addr == A_MSCRATCH)
        r_mscratch <= w_wdata;
      if (w_wr && addr == A_MCYCLE)
        r_mcycle <= w_wdata;
      else
        r_mcycle <= r_mcycle + N'(1);
      if (w_wr && addr == A_MINSTRET)
        r_minstret <= w_wdata;
      else if (retire)
        r_minstret <= r_minstret + N'(1);
    end
  end

  assign mtvec_o = r_mtvec;
  assign mepc_o  = r_mepc;
  assign mie_o   = r_st_mie;

  logic w_unused;
  assign w_unused = w_sys_evt;

endmodule
